// File: rtl/router_fsm_if.sv
// router_fsm_if: packet-source, FIFO status and state-decode signals of the router control FSM.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;
  modport master (
    output pkt_valid, data_in, fifo_full, parity_done, low_pkt_valid,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2, soft_reset_0, soft_reset_1, soft_reset_2,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy
  );
  modport slave (
    input  pkt_valid, data_in, fifo_full, parity_done, low_pkt_valid,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2, soft_reset_0, soft_reset_1, soft_reset_2,
    output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: Moore control FSM of a 3-port packet router.
// Define ROUTER_FSM_DROP_BAD_ADDR_EN to swallow packets addressed to port 3 in a DROP_PACKET state.
module router_fsm (
  input logic       clock,
  input logic       resetn,
  router_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
    LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
`ifdef ROUTER_FSM_DROP_BAD_ADDR_EN
    , DROP_PACKET
`endif
  } state_e;
  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] empty_v, srst_v;
  // port 3 does not exist: never empty, never times out
  assign empty_v = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign srst_v  = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: if (bus.pkt_valid) begin
        addr_d = bus.data_in;
        if (bus.data_in != 2'd3) state_d = empty_v[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_DROP_BAD_ADDR_EN
        else state_d = DROP_PACKET;
`endif
      end
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA:          state_d = bus.fifo_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    state_d = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    state_d = bus.parity_done ? DECODE_ADDRESS : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    state_d = empty_v[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_DROP_BAD_ADDR_EN
      DROP_PACKET:        state_d = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
`endif
      default:            state_d = DECODE_ADDRESS;
    endcase
    if (state_q != DECODE_ADDRESS && srst_v[addr_q]) state_d = DECODE_ADDRESS;
  end
  assign bus.detect_add    = state_q == DECODE_ADDRESS;
  assign bus.lfd_state     = state_q == LOAD_FIRST_DATA;
  assign bus.ld_state      = state_q == LOAD_DATA;
  assign bus.laf_state     = state_q == LOAD_AFTER_FULL;
  assign bus.full_state    = state_q == FIFO_FULL_STATE;
  assign bus.rst_int_reg   = state_q == CHECK_PARITY_ERROR;
  assign bus.write_enb_reg = state_q == LOAD_DATA || state_q == LOAD_AFTER_FULL || state_q == LOAD_PARITY;
  assign bus.busy          = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scenarios plus random traffic against a table-driven reference model.
module tb_router_fsm;
  localparam int DA = 0, LFD = 1, LD = 2, FFS = 3, LAF = 4, LP = 5, CPE = 6, WTE = 7, DRP = 8;
`ifdef ROUTER_FSM_DROP_BAD_ADDR_EN
  localparam bit DROP_EN = 1'b1;
  localparam int BAD = DRP;
`else
  localparam bit DROP_EN = 1'b0;
  localparam int BAD = DA;
`endif
  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy} per state
  localparam logic [7:0] TBL [9] = '{8'h80, 8'h41, 8'h24, 8'h09, 8'h15, 8'h05, 8'h03, 8'h01, 8'h01};
  logic clock = 1'b0;
  logic resetn;
  logic pv, ff, pd, lpv;
  logic [1:0] din;
  logic [2:0] fe, sr;
  logic [7:0] outs;
  int checks = 0, errors = 0, wr_cnt = 0;
  int ms = DA, ma = 0;
  router_fsm_if bus();
  router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  assign bus.pkt_valid     = pv;
  assign bus.data_in       = din;
  assign bus.fifo_full     = ff;
  assign bus.parity_done   = pd;
  assign bus.low_pkt_valid = lpv;
  assign bus.fifo_empty_0  = fe[0];
  assign bus.fifo_empty_1  = fe[1];
  assign bus.fifo_empty_2  = fe[2];
  assign bus.soft_reset_0  = sr[0];
  assign bus.soft_reset_1  = sr[1];
  assign bus.soft_reset_2  = sr[2];
  assign outs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                 bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int nxt();
    int n = ms;
    case (ms)
      DA:  if (pv) n = (din == 2'd3) ? (DROP_EN ? DRP : DA) : (fe[din] ? LFD : WTE);
      LFD: n = LD;
      LD:  n = ff ? FFS : (pv ? LD : LP);
      FFS: n = ff ? FFS : LAF;
      LAF: n = pd ? DA : (lpv ? LP : LD);
      LP:  n = CPE;
      CPE: n = ff ? FFS : DA;
      WTE: n = fe[ma] ? LFD : WTE;
      DRP: n = pv ? DRP : DA;
      default: n = DA;
    endcase
    if (ms != DA && ma < 3 && sr[ma]) n = DA;
    return n;
  endfunction
  task automatic tick();
    int n, na;
    n  = nxt();
    na = (ms == DA && pv) ? int'(din) : ma;
    @(posedge clock);
    ms = n;
    ma = na;
    @(negedge clock);
    chk("model", outs, TBL[ms]);
    if (outs[2]) wr_cnt++;
  endtask
  task automatic step(input string tag, input int exp);
    tick();
    chk(tag, outs, TBL[exp]);
  endtask
  task automatic async_rst();
    #2 resetn = 1'b0;
    #1 chk("async_rst", outs, 8'h80);
    #1 resetn = 1'b1;
    ms = DA;
    ma = 0;
  endtask
  initial begin
    resetn = 1'b0;
    {pv, ff, pd, lpv, din, sr} = '0;
    fe = 3'b111;
    #1 chk("reset", outs, 8'h80);
    @(negedge clock);
    resetn = 1'b1;
    pv = 1; din = 1; wr_cnt = 0;
    step("p1_lfd", LFD);
    step("p1_ld1", LD);
    step("p1_ld2", LD);
    step("p1_ld3", LD);
    pv = 0;
    step("p1_lp", LP);
    step("p1_cpe", CPE);
    step("p1_da", DA);
    chk("p1_wr_cnt", 8'(wr_cnt), 8'd4);
    pv = 1; din = 0;
    step("full_lfd", LFD);
    step("full_ld", LD);
    ff = 1;
    step("full_ffs1", FFS);
    step("full_ffs2", FFS);
    ff = 0;
    step("full_laf", LAF);
    step("full_ld2", LD);
    pv = 0;
    step("full_lp", LP);
    step("full_cpe", CPE);
    step("full_da", DA);
    fe = 3'b011; pv = 1; din = 2;
    step("wte1", WTE);
    pv = 0;
    for (int i = 0; i < 4; i++) step("wte", WTE);
    fe = 3'b111;
    step("wte_lfd", LFD);
    step("wte_ld", LD);
    step("wte_lp", LP);
    step("wte_cpe", CPE);
    step("wte_da", DA);
    pv = 1; din = 0;
    step("sr_lfd", LFD);
    step("sr_ld", LD);
    ff = 1;
    step("sr_ffs", FFS);
    sr = 3'b010;
    step("sr_other", FFS);
    sr = 3'b001;
    step("sr_own", DA);
    sr = 0; ff = 0; pv = 1; din = 1;
    step("ar_lfd", LFD);
    step("ar_ld", LD);
    async_rst();
    step("ar_restart", LFD);
    pv = 0;
    step("ar_ld2", LD);
    step("ar_lp", LP);
    step("ar_cpe", CPE);
    step("ar_da", DA);
    pv = 1; din = 3; wr_cnt = 0;
    step("bad1", BAD);
    step("bad2", BAD);
    pv = 0;
    step("bad_end", DA);
    chk("bad_wr_cnt", 8'(wr_cnt), 8'd0);
    for (int i = 0; i < 3000; i++) begin
      pv  = $urandom_range(0, 3) != 0;
      din = 2'($urandom_range(0, 3));
      ff  = $urandom_range(0, 4) == 0;
      pd  = $urandom_range(0, 3) == 0;
      lpv = $urandom_range(0, 2) == 0;
      fe  = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
      sr  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if ($urandom_range(0, 99) == 0) async_rst();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
